// File: rtl/mem_arb_pkg.sv
// Shared types for the two-client memory arbiter: client IDs and arbiter states.
package mem_arb_pkg;

  localparam int ID_W = 1;

  typedef enum logic [ID_W-1:0] {
    CL_IC = 1'b0,
    CL_DC = 1'b1
  } client_e;

  typedef enum logic {
    ARB,
    WDATA
  } state_e;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of client IDs for outstanding reads; head is visible combinationally.
module mem_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic [ID_W-1:0] din,
  output logic [ID_W-1:0] dout,
  output logic            full,
  output logic            empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_reg];

  // Storage has no reset: only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin merge of I-cache and D-cache memory ports onto one memory port.
// Optional statistics counters are enabled with MEM_ARB_STATS_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ic_req_val,
  output logic                ic_req_rdy,
  input  logic [ADDR_W-1:0]   ic_req_addr,
  input  logic                ic_req_rw,
  input  logic                ic_req_data_valid,
  output logic                ic_req_data_ready,
  input  logic [DATA_W-1:0]   ic_req_data_bits,
  input  logic [DATA_W/8-1:0] ic_req_data_mask,
  output logic                ic_resp_val,
  output logic [DATA_W-1:0]   ic_resp_data,
  input  logic                dc_req_val,
  output logic                dc_req_rdy,
  input  logic [ADDR_W-1:0]   dc_req_addr,
  input  logic                dc_req_rw,
  input  logic                dc_req_data_valid,
  output logic                dc_req_data_ready,
  input  logic [DATA_W-1:0]   dc_req_data_bits,
  input  logic [DATA_W/8-1:0] dc_req_data_mask,
  output logic                dc_resp_val,
  output logic [DATA_W-1:0]   dc_resp_data,
  output logic                mem_req_val,
  input  logic                mem_req_rdy,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_rw,
  output logic                mem_req_data_valid,
  input  logic                mem_req_data_ready,
  output logic [DATA_W-1:0]   mem_req_data_bits,
  output logic [DATA_W/8-1:0] mem_req_data_mask,
  input  logic                mem_resp_val,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                err_spurious
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]         stat_ic_grants,
  output logic [31:0]         stat_dc_grants,
  output logic [31:0]         stat_stall_cycles
`endif
);

  state_e    state_reg, state_next;
  client_e   rr_ptr_reg, rr_ptr_next;
  client_e   owner_reg, owner_next;
  client_e   sel;
  logic      sel_val;
  logic      sel_rw;
  logic      req_val;
  logic      fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ID_W-1:0] fifo_dout;
  logic      err_spurious_reg;

  always_comb begin
    sel = CL_IC;
    if (ic_req_val && dc_req_val) sel = rr_ptr_reg;
    else if (dc_req_val)          sel = CL_DC;
    sel_val           = ic_req_val | dc_req_val;
    sel_rw            = (sel == CL_DC) ? dc_req_rw : ic_req_rw;
    mem_req_addr      = (sel == CL_DC) ? dc_req_addr : ic_req_addr;
    mem_req_rw        = sel_rw;
    mem_req_data_bits = (owner_reg == CL_DC) ? dc_req_data_bits : ic_req_data_bits;
    mem_req_data_mask = (owner_reg == CL_DC) ? dc_req_data_mask : ic_req_data_mask;
    req_val            = 1'b0;
    ic_req_rdy         = 1'b0;
    dc_req_rdy         = 1'b0;
    mem_req_data_valid = 1'b0;
    ic_req_data_ready  = 1'b0;
    dc_req_data_ready  = 1'b0;
    fifo_push          = 1'b0;
    state_next         = state_reg;
    rr_ptr_next        = rr_ptr_reg;
    owner_next         = owner_reg;
    // Every val/rdy stays low while reset_n is asserted.
    if (reset_n) begin
      case (state_reg)
        ARB: begin
          req_val = sel_val & ~(~sel_rw & fifo_full);
          if (sel == CL_DC) dc_req_rdy = mem_req_rdy & req_val;
          else              ic_req_rdy = mem_req_rdy & req_val;
          if (req_val && mem_req_rdy) begin
            rr_ptr_next = (sel == CL_IC) ? CL_DC : CL_IC;
            if (sel_rw) begin
              owner_next = sel;
              state_next = WDATA;
            end else begin
              fifo_push = 1'b1;
            end
          end
        end
        WDATA: begin
          if (owner_reg == CL_DC) begin
            mem_req_data_valid = dc_req_data_valid;
            dc_req_data_ready  = mem_req_data_ready;
          end else begin
            mem_req_data_valid = ic_req_data_valid;
            ic_req_data_ready  = mem_req_data_ready;
          end
          if (mem_req_data_valid && mem_req_data_ready) state_next = ARB;
        end
        default: state_next = ARB;
      endcase
    end
    mem_req_val = req_val;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= ARB;
      rr_ptr_reg       <= CL_IC;
      owner_reg        <= CL_IC;
      err_spurious_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      owner_reg  <= owner_next;
      if (mem_resp_val && fifo_empty) err_spurious_reg <= 1'b1;
    end
  end

  mem_arb_id_fifo #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W)
  ) u_id_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (sel),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign fifo_pop     = reset_n & mem_resp_val & ~fifo_empty;
  assign ic_resp_val  = fifo_pop & (fifo_dout == CL_IC);
  assign dc_resp_val  = fifo_pop & (fifo_dout == CL_DC);
  assign ic_resp_data = mem_resp_data;
  assign dc_resp_data = mem_resp_data;
  assign err_spurious = err_spurious_reg;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] ic_grants_reg, dc_grants_reg, stall_reg;
  logic        stall;

  assign stall = (ic_req_val & ~ic_req_rdy) | (dc_req_val & ~dc_req_rdy);

  // All counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ic_grants_reg <= '0;
      dc_grants_reg <= '0;
      stall_reg     <= '0;
    end else begin
      if (ic_req_val && ic_req_rdy && ic_grants_reg != '1) ic_grants_reg <= ic_grants_reg + 1'b1;
      if (dc_req_val && dc_req_rdy && dc_grants_reg != '1) dc_grants_reg <= dc_grants_reg + 1'b1;
      if (stall && stall_reg != '1) stall_reg <= stall_reg + 1'b1;
    end
  end

  assign stat_ic_grants    = ic_grants_reg;
  assign stat_dc_grants    = dc_grants_reg;
  assign stat_stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a response scoreboard.
module tb_mem_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int MASK_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ic_req_val, ic_req_rdy, ic_req_rw, ic_req_data_valid, ic_req_data_ready;
  logic [ADDR_W-1:0] ic_req_addr;
  logic [DATA_W-1:0] ic_req_data_bits, ic_resp_data;
  logic [MASK_W-1:0] ic_req_data_mask;
  logic              ic_resp_val;
  logic              dc_req_val, dc_req_rdy, dc_req_rw, dc_req_data_valid, dc_req_data_ready;
  logic [ADDR_W-1:0] dc_req_addr;
  logic [DATA_W-1:0] dc_req_data_bits, dc_resp_data;
  logic [MASK_W-1:0] dc_req_data_mask;
  logic              dc_resp_val;
  logic              mem_req_val, mem_req_rdy, mem_req_rw, mem_req_data_valid, mem_req_data_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data_bits;
  logic [MASK_W-1:0] mem_req_data_mask;
  logic              mem_resp_val;
  logic [DATA_W-1:0] mem_resp_data;
  logic              err_spurious;
`ifdef MEM_ARB_STATS_EN
  logic [31:0]       stat_ic_grants, stat_dc_grants, stat_stall_cycles;
`endif

  typedef struct {
    logic              cl;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .ic_req_val         (ic_req_val),
    .ic_req_rdy         (ic_req_rdy),
    .ic_req_addr        (ic_req_addr),
    .ic_req_rw          (ic_req_rw),
    .ic_req_data_valid  (ic_req_data_valid),
    .ic_req_data_ready  (ic_req_data_ready),
    .ic_req_data_bits   (ic_req_data_bits),
    .ic_req_data_mask   (ic_req_data_mask),
    .ic_resp_val        (ic_resp_val),
    .ic_resp_data       (ic_resp_data),
    .dc_req_val         (dc_req_val),
    .dc_req_rdy         (dc_req_rdy),
    .dc_req_addr        (dc_req_addr),
    .dc_req_rw          (dc_req_rw),
    .dc_req_data_valid  (dc_req_data_valid),
    .dc_req_data_ready  (dc_req_data_ready),
    .dc_req_data_bits   (dc_req_data_bits),
    .dc_req_data_mask   (dc_req_data_mask),
    .dc_resp_val        (dc_resp_val),
    .dc_resp_data       (dc_resp_data),
    .mem_req_val        (mem_req_val),
    .mem_req_rdy        (mem_req_rdy),
    .mem_req_addr       (mem_req_addr),
    .mem_req_rw         (mem_req_rw),
    .mem_req_data_valid (mem_req_data_valid),
    .mem_req_data_ready (mem_req_data_ready),
    .mem_req_data_bits  (mem_req_data_bits),
    .mem_req_data_mask  (mem_req_data_mask),
    .mem_resp_val       (mem_resp_val),
    .mem_resp_data      (mem_resp_data),
    .err_spurious       (err_spurious)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_ic_grants     (stat_ic_grants),
    .stat_dc_grants     (stat_dc_grants),
    .stat_stall_cycles  (stat_stall_cycles)
`endif
  );

  // Response monitor: every response beat is checked against the scoreboard head.
  always @(negedge clk) begin
    if (mem_resp_val) begin
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        checks++;
        if (ic_resp_val !== (mon_e.cl == 1'b0) || dc_resp_val !== (mon_e.cl == 1'b1) ||
            ic_resp_data !== mon_e.data || dc_resp_data !== mon_e.data) begin
          errors++;
          $display("FAIL resp_route got ic_val=%0b dc_val=%0b ic_data=%h dc_data=%h exp client=%0d data=%h",
                   ic_resp_val, dc_resp_val, ic_resp_data, dc_resp_data, mon_e.cl, mon_e.data);
        end
        $display("RESP client=%0d data=%h", mon_e.cl, mon_e.data);
      end else begin
        checks++;
        if (ic_resp_val !== 1'b0 || dc_resp_val !== 1'b0) begin
          errors++;
          $display("FAIL spurious_drop got ic_val=%0b dc_val=%0b exp 0 0", ic_resp_val, dc_resp_val);
        end
        $display("RESP spurious data=%h dropped", mem_resp_data);
      end
    end else begin
      checks++;
      if (ic_resp_val !== 1'b0 || dc_resp_val !== 1'b0) begin
        errors++;
        $display("FAIL idle_resp got ic_val=%0b dc_val=%0b exp 0 0", ic_resp_val, dc_resp_val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input logic [DATA_W-1:0] d);
    mem_resp_val  = 1'b1;
    mem_resp_data = d;
    step();
    mem_resp_val  = 1'b0;
  endtask

  task automatic clear_inputs();
    ic_req_val = 0; ic_req_addr = '0; ic_req_rw = 0; ic_req_data_valid = 0;
    ic_req_data_bits = '0; ic_req_data_mask = '0;
    dc_req_val = 0; dc_req_addr = '0; dc_req_rw = 0; dc_req_data_valid = 0;
    dc_req_data_bits = '0; dc_req_data_mask = '0;
    mem_req_rdy = 1; mem_req_data_ready = 1; mem_resp_val = 0; mem_resp_data = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    ic_req_val = 1; dc_req_val = 1; dc_req_rw = 1; dc_req_data_valid = 1;
    @(negedge clk);
    checks++;
    if (ic_req_rdy !== 1'b0 || dc_req_rdy !== 1'b0 || mem_req_val !== 1'b0 || mem_req_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_forced got ic_rdy=%0b dc_rdy=%0b mem_val=%0b mem_dval=%0b exp all 0",
               ic_req_rdy, dc_req_rdy, mem_req_val, mem_req_data_valid);
    end
    step();
    clear_inputs();
    reset_n = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (ic_req_rdy !== 1'b0 || dc_req_rdy !== 1'b0 || mem_req_val !== 1'b0 || err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got ic_rdy=%0b dc_rdy=%0b mem_val=%0b err=%0b exp all 0",
               ic_req_rdy, dc_req_rdy, mem_req_val, err_spurious);
    end
    $display("TXN reset checked");
    step();
  endtask

  task automatic test_round_robin();
    ic_req_val = 1; ic_req_addr = 28'h10; ic_req_rw = 0;
    dc_req_val = 1; dc_req_addr = 28'h20; dc_req_rw = 0;
    @(negedge clk);
    checks++;
    if (ic_req_rdy !== 1'b1 || dc_req_rdy !== 1'b0 || mem_req_addr !== 28'h10 || mem_req_val !== 1'b1) begin
      errors++;
      $display("FAIL rr_first got ic_rdy=%0b dc_rdy=%0b addr=%h exp 1 0 10", ic_req_rdy, dc_req_rdy, mem_req_addr);
    end
    sb.push_back('{cl: 1'b0, data: 128'hAAAA_0001});
    $display("REQ ic read addr=10");
    step();
    ic_req_val = 0;
    @(negedge clk);
    checks++;
    if (dc_req_rdy !== 1'b1 || ic_req_rdy !== 1'b0 || mem_req_addr !== 28'h20) begin
      errors++;
      $display("FAIL rr_second got dc_rdy=%0b ic_rdy=%0b addr=%h exp 1 0 20", dc_req_rdy, ic_req_rdy, mem_req_addr);
    end
    sb.push_back('{cl: 1'b1, data: 128'hBBBB_0002});
    $display("REQ dc read addr=20");
    step();
    dc_req_val = 0;
    resp(128'hAAAA_0001);
    resp(128'hBBBB_0002);
  endtask

  task automatic test_write_lock();
    dc_req_val = 1; dc_req_rw = 1; dc_req_addr = 28'h5;
    dc_req_data_bits = 128'hD0D0_1234_5678; dc_req_data_mask = 16'h00F3; dc_req_data_valid = 0;
    ic_req_data_bits = 128'hDEAD; ic_req_data_mask = 16'hFFFF; ic_req_data_valid = 1;
    @(negedge clk);
    checks++;
    if (dc_req_rdy !== 1'b1 || mem_req_rw !== 1'b1 || mem_req_addr !== 28'h5 ||
        mem_req_data_valid !== 1'b0 || ic_req_data_ready !== 1'b0 || dc_req_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_grant got dc_rdy=%0b rw=%0b addr=%h dval=%0b exp 1 1 5 0",
               dc_req_rdy, mem_req_rw, mem_req_addr, mem_req_data_valid);
    end
    $display("REQ dc write addr=5");
    step();
    dc_req_val = 0;
    ic_req_val = 1; ic_req_rw = 0; ic_req_addr = 28'h30;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ic_req_rdy !== 1'b0 || mem_req_val !== 1'b0 || mem_req_data_valid !== 1'b0) begin
        errors++;
        $display("FAIL wr_wait%0d got ic_rdy=%0b mem_val=%0b dval=%0b exp 0 0 0",
                 i, ic_req_rdy, mem_req_val, mem_req_data_valid);
      end
      step();
    end
    dc_req_data_valid = 1;
    @(negedge clk);
    checks++;
    if (mem_req_data_valid !== 1'b1 || mem_req_data_mask !== 16'h00F3 || mem_req_data_bits !== 128'hD0D0_1234_5678 ||
        dc_req_data_ready !== 1'b1 || ic_req_data_ready !== 1'b0 || ic_req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL wr_beat got dval=%0b mask=%h bits=%h dc_drdy=%0b ic_drdy=%0b exp 1 00f3 d0d012345678 1 0",
               mem_req_data_valid, mem_req_data_mask, mem_req_data_bits, dc_req_data_ready, ic_req_data_ready);
    end
    $display("TXN dc write beat");
    step();
    dc_req_data_valid = 0; ic_req_data_valid = 0;
    @(negedge clk);
    checks++;
    if (ic_req_rdy !== 1'b1 || mem_req_addr !== 28'h30 || mem_req_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_after got ic_rdy=%0b addr=%h dval=%0b exp 1 30 0", ic_req_rdy, mem_req_addr, mem_req_data_valid);
    end
    sb.push_back('{cl: 1'b0, data: 128'hCCCC_0003});
    $display("REQ ic read addr=30");
    step();
    ic_req_val = 0;
    resp(128'hCCCC_0003);
  endtask

  task automatic test_fifo_full();
    ic_req_val = 1; ic_req_rw = 0;
    for (int i = 0; i < 4; i++) begin
      ic_req_addr = ADDR_W'(28'h40 + i);
      @(negedge clk);
      checks++;
      if (ic_req_rdy !== 1'b1) begin
        errors++;
        $display("FAIL fill%0d got ic_rdy=%0b exp 1", i, ic_req_rdy);
      end
      sb.push_back('{cl: 1'b0, data: DATA_W'(128'hF000 + i)});
      $display("REQ ic read addr=%h", ic_req_addr);
      step();
    end
    ic_req_addr = 28'h44;
    @(negedge clk);
    checks++;
    if (ic_req_rdy !== 1'b0 || mem_req_val !== 1'b0) begin
      errors++;
      $display("FAIL full_block got ic_rdy=%0b mem_val=%0b exp 0 0", ic_req_rdy, mem_req_val);
    end
    step();
    mem_resp_val = 1; mem_resp_data = 128'hF000;
    @(negedge clk);
    checks++;
    if (ic_req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_block got ic_rdy=%0b exp 0", ic_req_rdy);
    end
    step();
    mem_resp_val = 0;
    @(negedge clk);
    checks++;
    if (ic_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL after_pop got ic_rdy=%0b exp 1", ic_req_rdy);
    end
    sb.push_back('{cl: 1'b0, data: 128'hF004});
    $display("REQ ic read addr=44");
    step();
    ic_req_val = 0;
    for (int i = 1; i < 5; i++) resp(DATA_W'(128'hF000 + i));
  endtask

  task automatic test_back_to_back();
    ic_req_val = 1; ic_req_rw = 0; ic_req_addr = 28'h50;
    @(negedge clk);
    sb.push_back('{cl: 1'b0, data: 128'hE001});
    $display("REQ ic read addr=50");
    step();
    ic_req_val = 0;
    dc_req_val = 1; dc_req_rw = 0; dc_req_addr = 28'h60;
    mem_resp_val = 1; mem_resp_data = 128'hE001;
    @(negedge clk);
    checks++;
    if (dc_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL push_pop got dc_rdy=%0b exp 1", dc_req_rdy);
    end
    sb.push_back('{cl: 1'b1, data: 128'hE002});
    $display("REQ dc read addr=60 with concurrent response");
    step();
    dc_req_val = 0; mem_resp_val = 0;
    resp(128'hE002);
    @(negedge clk);
    checks++;
    if (err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL no_spurious got err=%0b exp 0", err_spurious);
    end
    step();
  endtask

  task automatic test_spurious();
    resp(128'h5555);
    @(negedge clk);
    checks++;
    if (err_spurious !== 1'b1) begin
      errors++;
      $display("FAIL spurious_set got err=%0b exp 1", err_spurious);
    end
    step(); step(); step();
    @(negedge clk);
    checks++;
    if (err_spurious !== 1'b1) begin
      errors++;
      $display("FAIL spurious_sticky got err=%0b exp 1", err_spurious);
    end
    step();
  endtask

  task automatic test_reset_outstanding();
    do_reset();
    @(negedge clk);
    checks++;
    if (err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared got err=%0b exp 0", err_spurious);
    end
    step();
    ic_req_val = 1; ic_req_rw = 0; ic_req_addr = 28'h70;
    step(); step();
    ic_req_val = 0;
    dc_req_val = 1; dc_req_rw = 1; dc_req_addr = 28'h71;
    step();
    dc_req_val = 0; dc_req_data_valid = 1;
    do_reset();
    @(negedge clk);
    checks++;
    if (mem_req_data_valid !== 1'b0 || dc_req_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_wdata got dval=%0b dc_drdy=%0b exp 0 0", mem_req_data_valid, dc_req_data_ready);
    end
    step();
    dc_req_data_valid = 0;
    resp(128'h7777);
    @(negedge clk);
    checks++;
    if (err_spurious !== 1'b1) begin
      errors++;
      $display("FAIL reset_discard got err=%0b exp 1", err_spurious);
    end
    $display("TXN reset with reads outstanding");
    step();
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin ic_req_val = 1; ic_req_rw = 0; end
      else            begin dc_req_val = 1; dc_req_rw = 0; end
      sb.push_back('{cl: 1'(i % 2), data: DATA_W'(128'hA100 + i)});
      step();
      ic_req_val = 0; dc_req_val = 0;
    end
    resp(128'hA100);
    resp(128'hA101);
    ic_req_val = 1;
    sb.push_back('{cl: 1'b0, data: 128'hA104});
    step();
    mem_req_rdy = 0;
    step(); step(); step(); step();
    ic_req_val = 0; mem_req_rdy = 1;
    @(negedge clk);
    checks++;
    if (stat_ic_grants !== 32'd3 || stat_dc_grants !== 32'd2 || stat_stall_cycles !== 32'd4) begin
      errors++;
      $display("FAIL stats got ic=%0d dc=%0d stall=%0d exp 3 2 4", stat_ic_grants, stat_dc_grants, stat_stall_cycles);
    end
    $display("TXN stats ic=%0d dc=%0d stall=%0d", stat_ic_grants, stat_dc_grants, stat_stall_cycles);
    step();
    resp(128'hA102);
    resp(128'hA103);
    resp(128'hA104);
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_write_lock();
    test_fifo_full();
    test_back_to_back();
    test_spurious();
    test_reset_outstanding();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
